// File: rtl/tetris_pkg.sv
// Shared board geometry, row type and line-clear FSM state encoding.
package tetris_pkg;

  localparam int unsigned ROWS = 20;
  localparam int unsigned COLS = 20;

  typedef logic [COLS-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    FILL,
    DONE
  } state_t;

endpackage

// File: rtl/line_clear.sv
// Line-clear engine: scans the board bottom-up and drops non-full rows
// down over removed full rows, then zero-fills the vacated top rows.
module line_clear
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS = tetris_pkg::ROWS,
  parameter int unsigned COLS = tetris_pkg::COLS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [4:0]      lines_cleared,
  output logic [4:0]      mem_rowid,
  output logic            mem_wnr,
  output logic [COLS-1:0] mem_wdata,
  input  logic [COLS-1:0] mem_rdata
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      wr_q, wr_d;
  logic [4:0]      lc_q, lc_d;
  logic [COLS-1:0] row_buf_q, row_buf_d;
  logic            row_full;

  assign row_full      = (mem_rdata == '1);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign lines_cleared = lc_q;

  // State, pointers, clear count and row buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_q      <= LAST_ROW;
      wr_q      <= LAST_ROW;
      lc_q      <= '0;
      row_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      lc_q      <= lc_d;
      row_buf_q <= row_buf_d;
    end
  end

  // Next-state, pointer updates and memory port drive.
  // Row 0 ends the scan instead of decrementing, so pointers never wrap;
  // on exit wr already addresses the highest row left to zero-fill.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    lc_d      = lc_q;
    row_buf_d = row_buf_q;
    mem_rowid = '0;
    mem_wnr   = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_d    = LAST_ROW;
          wr_d    = LAST_ROW;
          lc_d    = '0;
          state_d = READ;
        end
      end
      READ: begin
        mem_rowid = rd_q;
        row_buf_d = mem_rdata;
        if (row_full) begin
          lc_d = lc_q + 5'd1;
          if (rd_q == '0) state_d = FILL;
          else            rd_d    = rd_q - 5'd1;
        end else if (rd_q == wr_q) begin
          if (rd_q == '0) begin
            state_d = (lc_q != '0) ? FILL : DONE;
          end else begin
            rd_d = rd_q - 5'd1;
            wr_d = wr_q - 5'd1;
          end
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_rowid = wr_q;
        mem_wnr   = 1'b1;
        mem_wdata = row_buf_q;
        wr_d      = wr_q - 5'd1;
        if (rd_q == '0) begin
          state_d = FILL;
        end else begin
          rd_d    = rd_q - 5'd1;
          state_d = READ;
        end
      end
      FILL: begin
        mem_rowid = wr_q;
        mem_wnr   = 1'b1;
        if (wr_q == '0) state_d = DONE;
        else            wr_d    = wr_q - 5'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_clear.sv
// Randomized self-checking bench for line_clear with a board memory and a
// list-based reference model of the compaction.
module tb_line_clear;
  import tetris_pkg::*;

  localparam int NR = ROWS;
  localparam int NC = COLS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [4:0]    lines_cleared;
  logic [4:0]    mem_rowid;
  logic          mem_wnr;
  logic [NC-1:0] mem_wdata;
  logic [NC-1:0] mem_rdata;

  row_t board [NR];
  int   errors   = 0;
  int   checks   = 0;
  int   wr_count = 0;

  // Reference model results.
  row_t exp_b [NR];
  int   exp_lc;
  int   exp_nwrites;
  int   exp_done;
  int   exp_wrow  [$];
  row_t exp_wdata [$];

  always #5 clk = ~clk;

  line_clear #(.ROWS(NR), .COLS(NC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .mem_rowid     (mem_rowid),
    .mem_wnr       (mem_wnr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  assign mem_rdata = (int'(mem_rowid) < NR) ? board[mem_rowid] : '0;

  // Board memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_wnr) begin
      wr_count <= wr_count + 1;
      if (int'(mem_rowid) < NR) board[mem_rowid] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full rows vanish; surviving rows keep their order and settle at the
  // bottom; the vacated top rows become zero.
  task automatic build_model();
    int k;
    k = NR - 1;
    exp_lc = 0;
    exp_wrow.delete();
    exp_wdata.delete();
    for (int r = NR - 1; r >= 0; r--) begin
      if (board[r] == '1) begin
        exp_lc++;
      end else begin
        exp_b[k] = board[r];
        if (k != r) begin
          exp_wrow.push_back(k);
          exp_wdata.push_back(board[r]);
        end
        k--;
      end
    end
    exp_nwrites = exp_wrow.size();
    for (int r = exp_lc - 1; r >= 0; r--) begin
      exp_b[r] = '0;
      exp_wrow.push_back(r);
      exp_wdata.push_back('0);
    end
    exp_done = NR + exp_nwrites + exp_lc + 1;
  endtask

  // One pass with per-cycle comparison against the model.
  task automatic run_pass(input bit repulse, output int done_cyc);
    int cyc;
    int nreads;
    int exp_rd;
    int row;
    row_t data;
    build_model();
    done_cyc = -1;
    @(negedge clk);
    start  = 1'b1;
    cyc    = 0;
    nreads = 0;
    exp_rd = NR - 1;
    while (cyc < exp_done + 1) begin
      @(negedge clk);
      cyc++;
      check("busy", 64'(busy), 64'(cyc <= exp_done));
      check("done", 64'(done), 64'(cyc == exp_done));
      if (done && done_cyc < 0) done_cyc = cyc;
      if (busy && !done) begin
        if (mem_wnr) begin
          if (exp_wrow.size() == 0) begin
            check("extra_write", 64'(mem_rowid), 64'hFFFF);
          end else begin
            row  = exp_wrow.pop_front();
            data = exp_wdata.pop_front();
            check("write_row", 64'(mem_rowid), 64'(row));
            check("write_data", 64'(mem_wdata), 64'(data));
          end
        end else begin
          check("read_row", 64'(mem_rowid), 64'(exp_rd));
          exp_rd--;
          nreads++;
        end
      end else begin
        check("quiet_port", 64'({mem_wnr, mem_rowid, mem_wdata}), 64'(0));
      end
      if (cyc == exp_done) check("lines_cleared", 64'(lines_cleared), 64'(exp_lc));
      start = (repulse && cyc <= exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check("writes_left", 64'(exp_wrow.size()), 64'(0));
    check("reads", 64'(nreads), 64'(NR));
    for (int r = 0; r < NR; r++) check($sformatf("board[%0d]", r), 64'(board[r]), 64'(exp_b[r]));
    repeat (3) @(negedge clk);
    check("lc_hold", 64'(lines_cleared), 64'(exp_lc));
    check("idle", 64'(busy), 64'(0));
  endtask

  task automatic clear_board();
    for (int r = 0; r < NR; r++) board[r] = '0;
  endtask

  initial begin
    int   dc;
    int   wc;
    int   sel;
    bit   seen;
    reset_n = 1'b0;
    start   = 1'b0;
    clear_board();
    #2;
    check("rst_outputs", 64'({busy, done, lines_cleared, mem_wnr, mem_rowid, mem_wdata}), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Empty board.
    clear_board();
    run_pass(1'b0, dc);
    check("empty_done_cycle", 64'(dc), 64'(21));
    check("empty_lc", 64'(lines_cleared), 64'(0));

    // Single full bottom row.
    clear_board();
    board[19] = '1;
    board[18] = 20'h00001;
    run_pass(1'b0, dc);
    check("one_done_cycle", 64'(dc), 64'(41));
    check("one_lc", 64'(lines_cleared), 64'(1));
    check("one_row19", 64'(board[19]), 64'(20'h00001));
    check("one_row0", 64'(board[0]), 64'(0));

    // Two interleaved full rows.
    clear_board();
    board[19] = '1;
    board[18] = 20'h0000F;
    board[17] = '1;
    board[16] = 20'h000F0;
    run_pass(1'b0, dc);
    check("two_lc", 64'(lines_cleared), 64'(2));
    check("two_row19", 64'(board[19]), 64'(20'h0000F));
    check("two_row18", 64'(board[18]), 64'(20'h000F0));
    check("two_row1", 64'(board[1]), 64'(0));

    // Whole board full.
    for (int r = 0; r < NR; r++) board[r] = '1;
    run_pass(1'b0, dc);
    check("full_done_cycle", 64'(dc), 64'(41));
    check("full_lc", 64'(lines_cleared), 64'(20));

    // Start re-pulsed throughout a pass.
    clear_board();
    board[19] = '1;
    board[18] = 20'h00001;
    run_pass(1'b1, dc);
    check("repulse_done_cycle", 64'(dc), 64'(41));

    // Reset while a row write is on the port.
    clear_board();
    board[19] = '1;
    board[18] = 20'h00005;
    board[10] = 20'h12345;
    @(negedge clk);
    start = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_wnr) seen = 1'b1;
    end
    check("reset_wait_write", 64'(seen), 64'(1));
    #1 reset_n = 1'b0;
    #1;
    check("midpass_rst", 64'({busy, done, lines_cleared, mem_wnr, mem_rowid, mem_wdata}), 64'(0));
    wc = wr_count;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_writes_after_rst", 64'(wr_count), 64'(wc));
    run_pass(1'b0, dc);

    // Randomized boards.
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NR; r++) begin
        sel = $urandom_range(0, 9);
        if (sel < 3)      board[r] = '1;
        else if (sel < 5) board[r] = '0;
        else              board[r] = row_t'($urandom);
      end
      run_pass(1'($urandom_range(0, 1)), dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
